// File: rtl/rank_change_logger.sv
// rank_change_logger: logs each change of the tracked value as a
// {value, delta, stamp} record into a FWFT FIFO with a drop counter.
module rank_change_logger #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int STAMP_WIDTH = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     clr_drops,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_value,
  output logic [DATA_WIDTH-1:0]    out_delta,
  output logic [STAMP_WIDTH-1:0]   out_stamp,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_WIDTH-1:0]    drops
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  value;
    logic [DATA_WIDTH-1:0]  delta;
    logic [STAMP_WIDTH-1:0] stamp;
  } rec_t;

  rec_t                   mem_q [DEPTH];
  rec_t                   rec_d;
  rec_t                   head;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [DROP_WIDTH-1:0]  drops_q, drops_d;
  logic                   change, full, pop, push, drop;

  // Change detect, push/pop arbitration and next-state for all counters
  always_comb begin
    change  = (din != prev_q);
    full    = (level_q == FULL_LVL);
    pop     = out_valid && out_ready;
    push    = change && (!full || pop);
    drop    = change && full && !pop;
    rec_d   = '{value: din, delta: din - prev_q, stamp: stamp_q};
    prev_d  = din;
    stamp_d = stamp_q + STAMP_WIDTH'(1);
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    if (pop && !push) level_d = level_q - LW'(1);
    drops_d = drops_q;
    if (drop && drops_q != DROP_MAX) drops_d = drops_q + DROP_WIDTH'(1);
    if (clr_drops) drops_d = '0;
  end

  // State registers; reset wipes storage so no stale record survives
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q  <= '0;
      stamp_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drops_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q  <= prev_d;
      stamp_q <= stamp_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      drops_q <= drops_d;
      if (push) mem_q[wptr_q] <= rec_d;
    end
  end

  // First-word-fall-through head, masked to zero when empty
  always_comb begin
    head      = mem_q[rptr_q];
    out_valid = (level_q != '0);
    out_value = out_valid ? head.value : '0;
    out_delta = out_valid ? head.delta : '0;
    out_stamp = out_valid ? head.stamp : '0;
    level     = level_q;
    drops     = drops_q;
  end

endmodule

// File: tb/tb_rank_change_logger.sv
// tb_rank_change_logger: table vectors plus scoreboard model
// of the change logger, with hand sequences for corner cases.
module tb_rank_change_logger;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] din = '0;
  logic        clr_drops = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_value;
  logic [31:0] out_delta;
  logic [15:0] out_stamp;
  logic [3:0]  level;
  logic [7:0]  drops;

  rank_change_logger #(
    .DATA_WIDTH(32), .DEPTH(8), .STAMP_WIDTH(16), .DROP_WIDTH(8)
  ) dut (
    .clk(clk), .resetn(resetn), .din(din),
    .clr_drops(clr_drops), .out_ready(out_ready),
    .out_valid(out_valid), .out_value(out_value),
    .out_delta(out_delta), .out_stamp(out_stamp),
    .level(level), .drops(drops)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] d;
    logic [15:0] s;
  } rec_t;

  typedef struct {
    logic [31:0] din;
    bit          rdy;
    bit          clr;
    int          lvl;
    int          drp;
  } vec_t;

  rec_t        sb[$];
  logic [31:0] mprev;
  logic [15:0] mstamp;
  int          mdrops;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mprev  = '0;
    mstamp = '0;
    mdrops = 0;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    clr_drops = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check head, advance model, check level/drops
  task automatic step(input logic [31:0] d, input bit r, input bit c);
    bit   pop, ch;
    int   sz;
    rec_t nr;
    din       = d;
    out_ready = r;
    clr_drops = c;
    @(negedge clk);
    chk("valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("value", {32'd0, out_value}, {32'd0, sb[0].v});
      chk("delta", {32'd0, out_delta}, {32'd0, sb[0].d});
      chk("stamp", {48'd0, out_stamp}, {48'd0, sb[0].s});
    end
    sz  = sb.size();
    pop = (sz != 0) && r;
    ch  = (d != mprev);
    if (pop) void'(sb.pop_front());
    if (ch) begin
      if (sz < 8 || pop) begin
        nr.v = d;
        nr.d = d - mprev;
        nr.s = mstamp;
        sb.push_back(nr);
      end else if (mdrops != 255) begin
        mdrops++;
      end
    end
    if (c) mdrops = 0;
    mprev  = d;
    mstamp = mstamp + 16'd1;
    @(posedge clk);
    #1;
    chk("level", {60'd0, level}, 64'(sb.size()));
    chk("drops", {56'd0, drops}, 64'(mdrops));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{32'd0, 1'b1, 1'b0, 0, 0};
    tbl[1] = '{32'd5, 1'b1, 1'b0, 1, 0};
    tbl[2] = '{32'd5, 1'b1, 1'b0, 0, 0};
    tbl[3] = '{32'd9, 1'b1, 1'b0, 1, 0};
    tbl[4] = '{32'd9, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{32'd3, 1'b0, 1'b0, 1, 0};

    // reset state and idle with din held at 0
    do_reset();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_level", {60'd0, level}, 64'd0);
    chk("rst_drops", {56'd0, drops}, 64'd0);
    chk("rst_value", {32'd0, out_value}, 64'd0);
    for (int i = 0; i < 10; i++) step(32'd0, 1'b1, 1'b0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // basic change records and decreasing wrap delta
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].din, tbl[i].rdy, tbl[i].clr);
      chk("tbl_level", {60'd0, level}, 64'(tbl[i].lvl));
      chk("tbl_drops", {56'd0, drops}, 64'(tbl[i].drp));
      if (i == 1) begin
        chk("rec1_value", {32'd0, out_value}, 64'd5);
        chk("rec1_delta", {32'd0, out_delta}, 64'd5);
        chk("rec1_stamp", {48'd0, out_stamp}, 64'd1);
      end
      if (i == 3) begin
        chk("rec2_value", {32'd0, out_value}, 64'd9);
        chk("rec2_delta", {32'd0, out_delta}, 64'd4);
        chk("rec2_stamp", {48'd0, out_stamp}, 64'd3);
      end
    end
    chk("wrap_delta", {32'd0, out_delta}, 64'h0000_0000_FFFF_FFFA);
    chk("wrap_stamp", {48'd0, out_stamp}, 64'd5);

    // fill and drop, then drain in order
    do_reset();
    for (int i = 1; i <= 10; i++) step(32'(i), 1'b0, 1'b0);
    chk("fill_level", {60'd0, level}, 64'd8);
    chk("fill_drops", {56'd0, drops}, 64'd2);
    chk("fill_head", {32'd0, out_value}, 64'd1);
    for (int i = 0; i < 8; i++) step(32'd10, 1'b1, 1'b0);
    chk("drain_level", {60'd0, level}, 64'd0);

    // full with simultaneous pop and push
    for (int i = 11; i <= 18; i++) step(32'(i), 1'b0, 1'b0);
    step(32'd19, 1'b1, 1'b0);
    chk("fpp_level", {60'd0, level}, 64'd8);
    chk("fpp_drops", {56'd0, drops}, 64'd2);
    chk("fpp_head", {32'd0, out_value}, 64'd12);

    // drop counter saturation and clear priority
    for (int i = 0; i < 300; i++) step(32'(100 + i), 1'b0, 1'b0);
    chk("sat_drops", {56'd0, drops}, 64'd255);
    step(32'd7777, 1'b0, 1'b1);
    chk("clr_drops", {56'd0, drops}, 64'd0);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) step(32'd7777, 1'b1, 1'b0);
    chk("pre_rst_level", {60'd0, level}, 64'd5);
    #2 resetn = 1'b0;
    #1;
    chk("async_valid", {63'd0, out_valid}, 64'd0);
    chk("async_level", {60'd0, level}, 64'd0);
    chk("async_value", {32'd0, out_value}, 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
    step(32'd42, 1'b0, 1'b0);
    chk("restart_stamp", {48'd0, out_stamp}, 64'd0);
    chk("restart_value", {32'd0, out_value}, 64'd42);
    step(32'd42, 1'b1, 1'b0);
    chk("restart_level", {60'd0, level}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
